// File: rtl/joypad_scan_ctrl.sv
// joypad_scan_ctrl: autonomous P1/JOYP matrix scanner with per-key debounce
// and a single-cycle interrupt pulse on any debounced key press.
module joypad_scan_ctrl #(
  parameter int unsigned SETTLE_CYCLES    = 4,
  parameter int unsigned DEBOUNCE_SAMPLES = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scan_en,
  input  logic [1:0] sel_cpu,
  input  logic       cpu_read,
  input  logic [3:0] p1x_in,
  output logic       p14_sel_n,
  output logic       p15_sel_n,
  output logic [3:0] dir_state,
  output logic [3:0] btn_state,
  output logic       joy_irq,
  output logic       scan_busy
);

  localparam int unsigned SW = $clog2(SETTLE_CYCLES + 1);
  localparam int unsigned DW = $clog2(DEBOUNCE_SAMPLES + 1);
  localparam int unsigned NKEYS = 8;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    SETTLE_DIR = 3'd1,
    SAMPLE_DIR = 3'd2,
    SETTLE_BTN = 3'd3,
    SAMPLE_BTN = 3'd4
  } state_e;

  state_e            state_q;
  logic [SW-1:0]     settle_q;
  logic [NKEYS-1:0]  stable_q, stable_d;
  logic [DW-1:0]     match_q [NKEYS];
  logic [DW-1:0]     match_d [NKEYS];
  logic              irq_q, irq_d;

  logic              smp_dir, smp_btn;
  logic [NKEYS-1:0]  raw8;
  logic [NKEYS-1:0]  grp_mask;

  // Scan sequencer; a CPU read parks the current phase at the start of its settle window
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      settle_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          settle_q <= '0;
          if (scan_en) state_q <= SETTLE_DIR;
        end
        SETTLE_DIR, SETTLE_BTN: begin
          if (cpu_read) begin
            settle_q <= '0;
          end else if (settle_q == SW'(SETTLE_CYCLES - 1)) begin
            settle_q <= '0;
            state_q  <= (state_q == SETTLE_DIR) ? SAMPLE_DIR : SAMPLE_BTN;
          end else begin
            settle_q <= settle_q + SW'(1);
          end
        end
        SAMPLE_DIR: begin
          settle_q <= '0;
          state_q  <= cpu_read ? SETTLE_DIR : SETTLE_BTN;
        end
        SAMPLE_BTN: begin
          settle_q <= '0;
          if (cpu_read)     state_q <= SETTLE_BTN;
          else if (scan_en) state_q <= SETTLE_DIR;
          else              state_q <= IDLE;
        end
        default: begin
          settle_q <= '0;
          state_q  <= IDLE;
        end
      endcase
    end
  end

  // Select drive: CPU selection when idle or reading, otherwise the scanned group
  always_comb begin
    p14_sel_n = sel_cpu[0];
    p15_sel_n = sel_cpu[1];
    if (!cpu_read) begin
      case (state_q)
        SETTLE_DIR, SAMPLE_DIR: begin
          p14_sel_n = 1'b0;
          p15_sel_n = 1'b1;
        end
        SETTLE_BTN, SAMPLE_BTN: begin
          p14_sel_n = 1'b1;
          p15_sel_n = 1'b0;
        end
        default: begin
          p14_sel_n = sel_cpu[0];
          p15_sel_n = sel_cpu[1];
        end
      endcase
    end
  end

  assign smp_dir  = (state_q == SAMPLE_DIR) && !cpu_read;
  assign smp_btn  = (state_q == SAMPLE_BTN) && !cpu_read;
  assign raw8     = {~p1x_in, ~p1x_in};
  assign grp_mask = {{4{smp_btn}}, {4{smp_dir}}};

  // Per-key debounce: a key flips only after DEBOUNCE_SAMPLES consecutive disagreeing samples
  always_comb begin
    stable_d = stable_q;
    match_d  = match_q;
    for (int i = 0; i < NKEYS; i++) begin
      if (grp_mask[i]) begin
        if (raw8[i] == stable_q[i]) begin
          match_d[i] = '0;
        end else if (match_q[i] == DW'(DEBOUNCE_SAMPLES - 1)) begin
          stable_d[i] = ~stable_q[i];
          match_d[i]  = '0;
        end else begin
          match_d[i] = match_q[i] + DW'(1);
        end
      end
    end
    irq_d = |(stable_d & ~stable_q);
  end

  // Key image, match counters and interrupt pulse registers
  always_ff @(posedge clk) begin
    if (reset) begin
      stable_q <= '0;
      irq_q    <= 1'b0;
      for (int i = 0; i < NKEYS; i++) match_q[i] <= '0;
    end else begin
      stable_q <= stable_d;
      irq_q    <= irq_d;
      for (int i = 0; i < NKEYS; i++) match_q[i] <= match_d[i];
    end
  end

  assign dir_state = stable_q[3:0];
  assign btn_state = stable_q[7:4];
  assign joy_irq   = irq_q;
  assign scan_busy = (state_q != IDLE);

endmodule

// File: tb/tb_joypad_scan_ctrl.sv
// Directed bench for joypad_scan_ctrl with a simple key-matrix pad model.
module tb_joypad_scan_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       scan_en;
  logic [1:0] sel_cpu;
  logic       cpu_read;
  logic [3:0] p1x_in;
  logic       p14_sel_n, p15_sel_n;
  logic [3:0] dir_state, btn_state;
  logic       joy_irq, scan_busy;

  // Active-low pin levels of each key group as seen when its select is low
  logic [3:0] dir_pins;
  logic [3:0] btn_pins;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int irq_cnt = 0;

  joypad_scan_ctrl #(.SETTLE_CYCLES(4), .DEBOUNCE_SAMPLES(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .scan_en   (scan_en),
    .sel_cpu   (sel_cpu),
    .cpu_read  (cpu_read),
    .p1x_in    (p1x_in),
    .p14_sel_n (p14_sel_n),
    .p15_sel_n (p15_sel_n),
    .dir_state (dir_state),
    .btn_state (btn_state),
    .joy_irq   (joy_irq),
    .scan_busy (scan_busy)
  );

  always #5 clk = ~clk;

  // Pad model: a selected group pulls the return lines of its pressed keys low
  always_comb begin
    p1x_in = 4'hF & (p14_sel_n ? 4'hF : dir_pins) & (p15_sel_n ? 4'hF : btn_pins);
  end

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Advance one clock; cyc then names the cycle now in progress
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (joy_irq) irq_cnt++;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) step();
  endtask

  // Two reset cycles, then cyc=0 so the next edge is edge 0
  task automatic do_reset();
    reset    = 1'b1;
    scan_en  = 1'b0;
    cpu_read = 1'b0;
    step();
    step();
    reset = 1'b0;
    cyc   = 0;
    irq_cnt = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    reset    = 1'b1;
    scan_en  = 1'b0;
    cpu_read = 1'b0;
    sel_cpu  = 2'b01;
    dir_pins = 4'hF;
    btn_pins = 4'hF;

    // Reset state
    do_reset();
    check_eq("rst_dir",  8'(dir_state), 8'h0);
    check_eq("rst_btn",  8'(btn_state), 8'h0);
    check_eq("rst_irq",  8'(joy_irq), 8'h0);
    check_eq("rst_busy", 8'(scan_busy), 8'h0);
    check_eq("rst_sel",  8'({p15_sel_n, p14_sel_n}), 8'h1);

    // Direction press: right held
    dir_pins = 4'b1110;
    scan_en  = 1'b1;
    run_to(1);
    check_eq("dp_busy1", 8'(scan_busy), 8'h1);
    check_eq("dp_sel1",  8'({p15_sel_n, p14_sel_n}), 8'h2);
    run_to(5);
    check_eq("dp_sel5",  8'({p15_sel_n, p14_sel_n}), 8'h2);
    run_to(10);
    check_eq("dp_sel10", 8'({p15_sel_n, p14_sel_n}), 8'h1);
    run_to(25);
    check_eq("dp_dir25", 8'(dir_state), 8'h0);
    check_eq("dp_irq25", 8'(irq_cnt), 8'h0);
    run_to(26);
    check_eq("dp_dir26", 8'(dir_state), 8'h1);
    check_eq("dp_irq26", 8'(joy_irq), 8'h1);
    run_to(27);
    check_eq("dp_irq27", 8'(joy_irq), 8'h0);
    check_eq("dp_btn27", 8'(btn_state), 8'h0);
    check_eq("dp_irqn",  8'(irq_cnt), 8'h1);
    // Reset clears the debounced image
    reset = 1'b1;
    run_to(28);
    reset = 1'b0;
    check_eq("dp_rst_dir",  8'(dir_state), 8'h0);
    check_eq("dp_rst_busy", 8'(scan_busy), 8'h0);

    // Glitch rejection: button A low only in two sample windows
    dir_pins = 4'hF;
    btn_pins = 4'hF;
    do_reset();
    scan_en = 1'b1;
    run_to(10); btn_pins = 4'b1110;
    run_to(11); btn_pins = 4'hF;
    run_to(20); btn_pins = 4'b1110;
    run_to(21); btn_pins = 4'hF;
    run_to(32);
    check_eq("gl_btn", 8'(btn_state), 8'h0);
    check_eq("gl_irq", 8'(irq_cnt), 8'h0);

    // Press then release start
    do_reset();
    btn_pins = 4'b0111;
    scan_en  = 1'b1;
    run_to(30);
    check_eq("rl_btn30", 8'(btn_state), 8'h0);
    run_to(31);
    check_eq("rl_btn31", 8'(btn_state), 8'h8);
    check_eq("rl_irq31", 8'(joy_irq), 8'h1);
    btn_pins = 4'hF;
    irq_cnt  = 0;
    run_to(60);
    check_eq("rl_btn60", 8'(btn_state), 8'h8);
    run_to(61);
    check_eq("rl_btn61", 8'(btn_state), 8'h0);
    check_eq("rl_irq",   8'(irq_cnt), 8'h0);

    // CPU read override during SETTLE_BTN (scan_en seen at edge 5)
    btn_pins = 4'hF;
    sel_cpu  = 2'b11;
    do_reset();
    run_to(5);
    check_eq("cr_busy5", 8'(scan_busy), 8'h0);
    check_eq("cr_sel5",  8'({p15_sel_n, p14_sel_n}), 8'h3);
    scan_en = 1'b1;
    run_to(12);
    sel_cpu  = 2'b10;
    cpu_read = 1'b1;
    #1;
    check_eq("cr_sel12", 8'({p15_sel_n, p14_sel_n}), 8'h2);
    run_to(13);
    check_eq("cr_sel13", 8'({p15_sel_n, p14_sel_n}), 8'h2);
    check_eq("cr_busy13", 8'(scan_busy), 8'h1);
    run_to(14);
    cpu_read = 1'b0;
    #1;
    check_eq("cr_sel14", 8'({p15_sel_n, p14_sel_n}), 8'h1);
    run_to(18);
    check_eq("cr_sel18", 8'({p15_sel_n, p14_sel_n}), 8'h1);
    run_to(19);
    check_eq("cr_sel19", 8'({p15_sel_n, p14_sel_n}), 8'h2);

    // scan_en dropped mid-pass: pass completes, then IDLE
    sel_cpu = 2'b11;
    do_reset();
    scan_en = 1'b1;
    run_to(3);
    scan_en = 1'b0;
    run_to(10);
    check_eq("se_busy10", 8'(scan_busy), 8'h1);
    check_eq("se_sel10",  8'({p15_sel_n, p14_sel_n}), 8'h1);
    run_to(11);
    check_eq("se_busy11", 8'(scan_busy), 8'h0);
    check_eq("se_sel11",  8'({p15_sel_n, p14_sel_n}), 8'h3);
    sel_cpu = 2'b10;
    #1;
    check_eq("se_selcomb", 8'({p15_sel_n, p14_sel_n}), 8'h2);
    run_to(15);
    check_eq("se_busy15", 8'(scan_busy), 8'h0);

    // Reset mid-pass aborts immediately
    sel_cpu = 2'b11;
    do_reset();
    scan_en = 1'b1;
    run_to(7);
    reset = 1'b1;
    run_to(8);
    check_eq("rm_busy8", 8'(scan_busy), 8'h0);
    check_eq("rm_sel8",  8'({p15_sel_n, p14_sel_n}), 8'h3);
    check_eq("rm_img8",  8'({btn_state, dir_state}), 8'h00);
    check_eq("rm_irq8",  8'(joy_irq), 8'h0);
    reset   = 1'b0;
    scan_en = 1'b0;
    run_to(9);
    check_eq("rm_busy9", 8'(scan_busy), 8'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/joypad_scan_ctrl.md
# joypad_scan_ctrl

Autonomous scan, debounce and interrupt controller for the P1/JOYP key matrix. It drives the P14/P15 select lines and samples the P10–P13 return lines. It keeps a debounced 8-key image and pulses the joypad interrupt request on any debounced press. When the CPU reads FF00 it yields the select lines to the CPU-written FF00 select bits, so the register read path sees the CPU's own selection.

## Interface
Parameters:
- SETTLE_CYCLES, 4, number of cycles the select lines are held before a sample (≥1)
- DEBOUNCE_SAMPLES, 3, number of consecutive equal samples needed to change a key's stable state (≥1)

Ports:
- clk  in  1  system clock; single clock domain
- reset  in  1  synchronous, active-high reset
- scan_en  in  1  enables autonomous scanning
- sel_cpu  in  2  CPU-written FF00 bits {5,4}; active-low {P15,P14}
- cpu_read  in  1  CPU is reading FF00 this cycle
- p1x_in  in  4  P13..P10 pin levels; active-low (1 = released)
- p14_sel_n  out  1  P14 select drive, active-low (direction group)
- p15_sel_n  out  1  P15 select drive, active-low (button group)
- dir_state  out  4  debounced {down,up,left,right}; 1 = pressed
- btn_state  out  4  debounced {start,select,b,a}; 1 = pressed
- joy_irq  out  1  one-cycle pulse on any debounced 0→1 key transition
- scan_busy  out  1  high in every state except IDLE

## Operation
FSM states: IDLE, SETTLE_DIR, SAMPLE_DIR, SETTLE_BTN, SAMPLE_BTN.

Select outputs per state:
- IDLE: {p15_sel_n,p14_sel_n} = sel_cpu.
- SETTLE_DIR / SAMPLE_DIR: p14_sel_n=0, p15_sel_n=1.
- SETTLE_BTN / SAMPLE_BTN: p14_sel_n=1, p15_sel_n=0.

Transitions:
- IDLE → SETTLE_DIR when scan_en=1.
- SETTLE_x lasts exactly SETTLE_CYCLES cycles (settle counter runs 0..SETTLE_CYCLES-1), then goes to SAMPLE_x.
- SAMPLE_x lasts 1 cycle. SAMPLE_DIR → SETTLE_BTN.
- SAMPLE_BTN → SETTLE_DIR if scan_en=1, else IDLE.
- scan_en is checked only in IDLE and at SAMPLE_BTN. Dropping it mid-scan finishes the current scan pass.

Sampling and debounce:
- In SAMPLE_DIR, ~p1x_in is the raw direction sample; in SAMPLE_BTN, ~p1x_in is the raw button sample.
- Each of the 8 keys has a stable bit and a match counter of width clog2(DEBOUNCE_SAMPLES+1).
- On a sample of the key's group:
  - raw == stable: counter is cleared.
  - raw != stable: counter increments. When it reaches DEBOUNCE_SAMPLES, stable flips and the counter clears.
- A key's counter only advances on its own group's sample.

Interrupt:
- joy_irq=1 in the cycle a stable bit changes 0→1.
- If several keys change together, it is still one pulse.
- Releases (1→0) never raise joy_irq.

CPU read override:
- While cpu_read=1 in any non-IDLE state, the select outputs follow sel_cpu and the FSM holds state.
- A SAMPLE_x state coinciding with cpu_read does not sample and is not consumed.
- On the first cycle after cpu_read falls, the current phase re-enters its SETTLE_x state with the counter cleared.

Reset (synchronous, active-high):
- state=IDLE, counters=0, dir_state=0, btn_state=0, joy_irq=0, scan_busy=0.
- p14_sel_n and p15_sel_n follow sel_cpu (IDLE rule).
- Reset mid-scan aborts the pass immediately; no sample is taken that cycle.

## Timing
- All outputs registered except the select lines in IDLE and during cpu_read, which are combinational from sel_cpu.
- Scan period: 2·(SETTLE_CYCLES+1) cycles, which is 10 cycles with default parameters.
- If scan_en is seen high at edge N, SETTLE_DIR begins at cycle N+1. SAMPLE_DIR is at N+1+SETTLE_CYCLES, and SAMPLE_BTN follows SETTLE_CYCLES+1 cycles later.
- A stable bit and joy_irq update in the cycle after the deciding SAMPLE cycle.
- Minimum press latency: (DEBOUNCE_SAMPLES-1)·period + SETTLE_CYCLES + 2 cycles from the first good sample window.

## Test plan
Defaults SETTLE=4, DEB=3; scan_en rises before edge 0.

- Reset check: assert reset with sel_cpu=2'b01 → dir_state=0, btn_state=0, joy_irq=0, scan_busy=0, p15_sel_n=0, p14_sel_n=1.
- Direction press: p1x_in=4'b1110 whenever p14_sel_n=0, else 4'b1111 → SAMPLE_DIR at cycles 5, 15, 25. At cycle 26 dir_state=4'b0001 and joy_irq pulses exactly one cycle; btn_state stays 0.
- Glitch rejection: button A low only during SAMPLE_BTN at cycles 10 and 20, high at 30 → btn_state stays 0, no joy_irq.
- Release: after a stable press of start, release it → btn_state[3] clears one cycle after the 3rd released SAMPLE_BTN; joy_irq stays 0.
- CPU read override: cpu_read=1 at cycles 12–13 (SETTLE_BTN) with sel_cpu=2'b10 → p14_sel_n=0, p15_sel_n=1 during those cycles. SETTLE_BTN restarts at cycle 14 and SAMPLE_BTN moves to cycle 18. At SAMPLE_BTN, sel_n = {p15,p14} = 2'b01 (P15 low).
- scan_en drop: deassert at cycle 3 → pass completes through SAMPLE_BTN at cycle 10, IDLE from 11, scan_busy=0, selects equal sel_cpu. Reset asserted at cycle 7 instead → IDLE at cycle 8, all state cleared.
